// File: rtl/code_scan_ctrl_if.sv
// rtl/code_scan_ctrl_if.sv - control, detector and result signals between the scan sequencer and its user
interface code_scan_ctrl_if #(
    parameter int CODE_W = 8
);
    logic              start;
    logic              abort;
    logic              step;
    logic              match;
    logic [CODE_W-1:0] code_out;
    logic              busy;
    logic              done;
    logic [CODE_W:0]   match_cnt;
    logic              any_match;
    logic [CODE_W-1:0] first_code;
    logic [CODE_W-1:0] last_code;

    modport slave (
        input  start, abort, step, match,
        output code_out, busy, done, match_cnt, any_match, first_code, last_code
    );

    modport master (
        output start, abort, step, match,
        input  code_out, busy, done, match_cnt, any_match, first_code, last_code
    );
endinterface

// File: rtl/code_scan_ctrl.sv
// rtl/code_scan_ctrl.sv - detector code sweeper and match statistics collector; optional CODE_SCAN_STEP_EN single-step mode
module code_scan_ctrl #(
    parameter int CODE_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    code_scan_ctrl_if.slave    bus
);
    // One bit per active state so busy/done are single flop outputs.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    state_t            r_state;
    state_t            w_next;
    logic              r_start_q;
    logic              r_armed;
    logic              w_start_edge;
    logic              w_adv;
    logic              w_last;
    logic              w_busy;
    logic              w_done;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_first;
    logic [CODE_W-1:0] r_last;
    logic [CODE_W:0]   r_cnt;
    logic              r_any;

    // Edge detect on start; r_armed blocks a level already high when reset lifts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            if (!bus.start) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_start_edge = bus.start & ~r_start_q & r_armed;
    assign w_last       = (r_code == CODE_MAX);

`ifdef CODE_SCAN_STEP_EN
    logic r_step_q;

    // Rising-edge detect on the single-step request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= bus.step;
        end
    end

    assign w_adv = (r_state == S_SCAN) & bus.step & ~r_step_q;
`else
    // Free-run: step is accepted on the port but has no effect.
    assign w_adv = (r_state == S_SCAN) & (bus.step | 1'b1);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: abort wins over everything, start edges are ignored while scanning.
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_edge) w_next = S_SCAN;
                S_SCAN:  if (w_adv && w_last) w_next = S_DONE;
                S_DONE:  if (w_start_edge) w_next = S_SCAN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Status outputs decode directly from the one-bit-per-state register.
    always_comb begin
        w_busy = (r_state == S_SCAN);
        w_done = (r_state == S_DONE);
    end

    // Code counter and statistics; abort freezes everything as-is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code  <= '0;
            r_cnt   <= '0;
            r_any   <= 1'b0;
            r_first <= '0;
            r_last  <= '0;
        end else if (!bus.abort) begin
            if (w_start_edge && (r_state != S_SCAN)) begin
                r_code  <= '0;
                r_cnt   <= '0;
                r_any   <= 1'b0;
                r_first <= '0;
                r_last  <= '0;
            end else if (w_adv) begin
                if (bus.match) begin
                    r_cnt  <= r_cnt + (CODE_W+1)'(1);
                    r_last <= r_code;
                    r_any  <= 1'b1;
                    if (!r_any) begin
                        r_first <= r_code;
                    end
                end
                if (!w_last) begin
                    r_code <= r_code + CODE_W'(1);
                end
            end
        end
    end

    assign bus.code_out   = r_code;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.match_cnt  = r_cnt;
    assign bus.any_match  = r_any;
    assign bus.first_code = r_first;
    assign bus.last_code  = r_last;
endmodule

// File: tb/tb_code_scan_ctrl.sv
// tb/tb_code_scan_ctrl.sv - self-checking bench for code_scan_ctrl
module tb_code_scan_ctrl;
    localparam int CODE_W = 8;
    localparam int N      = 256;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    code_scan_ctrl_if #(.CODE_W(CODE_W)) bus();

    logic [N-1:0] r_pattern;
    assign bus.match = r_pattern[bus.code_out];

    code_scan_ctrl #(.CODE_W(CODE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] pat;
        int           cnt;
        int           any_m;
        int           first;
        int           last;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference statistics straight from the pattern: popcount, lowest and highest set code.
    task automatic ref_model(input logic [N-1:0] p, output int cnt, output int any_m,
                             output int first, output int last);
        cnt   = $countones(p);
        any_m = (cnt != 0) ? 1 : 0;
        first = 0;
        last  = 0;
        for (int i = N - 1; i >= 0; i--) if (p[i]) first = i;
        for (int i = 0; i < N; i++)      if (p[i]) last  = i;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code"},  int'(bus.code_out),   0);
        check({tag, "_busy"},  int'(bus.busy),       0);
        check({tag, "_done"},  int'(bus.done),       0);
        check({tag, "_cnt"},   int'(bus.match_cnt),  0);
        check({tag, "_any"},   int'(bus.any_match),  0);
        check({tag, "_first"}, int'(bus.first_code), 0);
        check({tag, "_last"},  int'(bus.last_code),  0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_code(input int target, input string tag);
        int n;
        n = 0;
        while (int'(bus.code_out) != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait_timeout"}, int'(n < 1000), 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_timeout"}, int'(n < 1000), 1);
    endtask

    // Full free-running scan from a start edge, checked against expected statistics.
    task automatic run_scan(input logic [N-1:0] p, input int ecnt, input int eany,
                            input int efirst, input int elast, input string tag,
                            input bit rand_step);
        int nb;
        r_pattern = p;
        pulse_start();
        check({tag, "_busy_e0"}, int'(bus.busy),     1);
        check({tag, "_code_e0"}, int'(bus.code_out), 0);
        nb = 0;
        while (bus.busy && nb < 1000) begin
            if (rand_step) bus.step = 1'($urandom_range(0, 1));
            nb++;
            @(negedge clk);
        end
        bus.step = 1'b0;
        check({tag, "_busy_cycles"}, nb,                    N);
        check({tag, "_done"},        int'(bus.done),        1);
        check({tag, "_cnt"},         int'(bus.match_cnt),   ecnt);
        check({tag, "_any"},         int'(bus.any_match),   eany);
        check({tag, "_first"},       int'(bus.first_code),  efirst);
        check({tag, "_last"},        int'(bus.last_code),   elast);
        check({tag, "_code_end"},    int'(bus.code_out),    N - 1);
    endtask

    logic [N-1:0] low2;
    logic [N-1:0] only5;
    vec_t         vecs[6];

    initial begin
        int ecnt, eany, efirst, elast;
        bit ok;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.step  = 1'b0;
        r_pattern = '0;
        low2      = '0;
        only5     = '0;
        for (int i = 0; i < N; i++) if ((i % 4) == 3) low2[i] = 1'b1;
        only5[5] = 1'b1;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef CODE_SCAN_STEP_EN
        vecs[0].pat = '0;    vecs[0].cnt = 0;   vecs[0].any_m = 0; vecs[0].first = 0; vecs[0].last = 0;
        vecs[1].pat = '1;    vecs[1].cnt = 256; vecs[1].any_m = 1; vecs[1].first = 0; vecs[1].last = 255;
        vecs[2].pat = low2;  vecs[2].cnt = 64;  vecs[2].any_m = 1; vecs[2].first = 3; vecs[2].last = 255;
        vecs[3].pat = only5; vecs[3].cnt = 1;   vecs[3].any_m = 1; vecs[3].first = 5; vecs[3].last = 5;
        vecs[4].pat = '0;    vecs[4].pat[255] = 1'b1;
        vecs[4].cnt = 1;     vecs[4].any_m = 1; vecs[4].first = 255; vecs[4].last = 255;
        vecs[5].pat = '0;    vecs[5].pat[0] = 1'b1;
        vecs[5].cnt = 1;     vecs[5].any_m = 1; vecs[5].first = 0;   vecs[5].last = 0;

        for (int v = 0; v < 6; v++) begin
            run_scan(vecs[v].pat, vecs[v].cnt, vecs[v].any_m, vecs[v].first, vecs[v].last,
                     $sformatf("vec%0d", v), 1'b0);
        end

        // Random detector truth tables with a random step level that must be ignored.
        for (int r = 0; r < 4; r++) begin
            logic [N-1:0] p;
            for (int w = 0; w < N / 32; w++) begin
                p[w*32 +: 32] = $urandom();
                if (r[0]) p[w*32 +: 32] = p[w*32 +: 32] & $urandom() & $urandom();
            end
            ref_model(p, ecnt, eany, efirst, elast);
            run_scan(p, ecnt, eany, efirst, elast, $sformatf("rand%0d", r), 1'b1);
        end

        // Start held high for 1000 cycles yields exactly one scan.
        begin
            int nb;
            r_pattern = low2;
            bus.start = 1'b1;
            nb = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (bus.busy) nb++;
            end
            bus.start = 1'b0;
            @(negedge clk);
            check("held_busy_cycles", nb, N);
            check("held_done", int'(bus.done), 1);
        end

        // Second start edge during SCAN is ignored.
        begin
            int nb;
            r_pattern = low2;
            pulse_start();
            nb = 0;
            for (int i = 0; i < 600; i++) begin
                if (i == 50) bus.start = 1'b1;
                if (i == 52) bus.start = 1'b0;
                if (bus.busy) nb++;
                @(negedge clk);
            end
            check("restart_busy_cycles", nb, N);
            check("restart_cnt", int'(bus.match_cnt), 64);
            check("restart_done", int'(bus.done), 1);
        end

        // Start edge in DONE clears results and rescans.
        r_pattern = '0;
        pulse_start();
        check("redone_cnt_clr",   int'(bus.match_cnt),  0);
        check("redone_any_clr",   int'(bus.any_match),  0);
        check("redone_first_clr", int'(bus.first_code), 0);
        check("redone_last_clr",  int'(bus.last_code),  0);
        check("redone_code_clr",  int'(bus.code_out),   0);
        check("redone_busy",      int'(bus.busy),       1);
        check("redone_done_lo",   int'(bus.done),       0);
        wait_done("redone");
        check("redone_final_cnt", int'(bus.match_cnt), 0);

        // Abort with a simultaneous start edge at code 0x40.
        r_pattern = low2;
        pulse_start();
        wait_code(8'h40, "abort");
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_busy",  int'(bus.busy),       0);
        check("abort_done",  int'(bus.done),       0);
        check("abort_code",  int'(bus.code_out),   8'h40);
        check("abort_cnt",   int'(bus.match_cnt),  16);
        check("abort_first", int'(bus.first_code), 3);
        check("abort_last",  int'(bus.last_code),  8'h3f);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_idle_busy", int'(bus.busy),     0);
        check("abort_idle_code", int'(bus.code_out), 8'h40);
        run_scan(low2, 64, 1, 3, 255, "post_abort", 1'b0);

        // Asynchronous reset mid-scan with start held high through it.
        r_pattern = low2;
        pulse_start();
        wait_code(8'h80, "areset");
        bus.start = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("areset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("areset_held_busy", int'(bus.busy),     0);
        check("areset_held_code", int'(bus.code_out), 0);
        bus.start = 1'b0;
        @(negedge clk);
        run_scan(low2, 64, 1, 3, 255, "post_reset", 1'b0);
`else
        // Step edges before the scan starts are ignored.
        r_pattern = only5;
        repeat (3) begin
            bus.step = 1'b1; @(negedge clk);
            bus.step = 1'b0; @(negedge clk);
        end
        check("pre_step_code", int'(bus.code_out), 0);
        pulse_start();
        check("step_busy_e0", int'(bus.busy), 1);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.code_out !== 8'h00) ok = 1'b0;
        end
        check("step_idle_hold", int'(ok), 1);
        repeat (6) begin
            bus.step = 1'b1; @(negedge clk);
            bus.step = 1'b0; @(negedge clk);
        end
        check("step6_code",  int'(bus.code_out),   6);
        check("step6_cnt",   int'(bus.match_cnt),  1);
        check("step6_any",   int'(bus.any_match),  1);
        check("step6_first", int'(bus.first_code), 5);
        check("step6_last",  int'(bus.last_code),  5);
        check("step6_busy",  int'(bus.busy),       1);
        repeat (N - 6) begin
            bus.step = 1'b1; @(negedge clk);
            bus.step = 1'b0; @(negedge clk);
        end
        check("stepall_done", int'(bus.done),      1);
        check("stepall_code", int'(bus.code_out),  N - 1);
        check("stepall_cnt",  int'(bus.match_cnt), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
